// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- pipeline execute stage with an EX/MEM output register.
//
// Single-cycle ALU ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU) are
// registered one edge after presentation.  With EX_STAGE_MUL_EN defined, MUL
// (alu_ctrl=10) runs on a 32-iteration shift-add multiplier.  While it runs,
// stall_out holds the upstream stages.  With the macro undefined, MUL is
// single-cycle with result 0 and stall_out is tied low.
//
// Configuration macro: EX_STAGE_MUL_EN (undefined by default).
//
// Handshake: stall_out is combinational.  While it is high, upstream must hold
// the ID/EX inputs unchanged.  A registered output is a real instruction only
// when out_valid=1.  Otherwise it is a bubble with every output field at zero.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   in_valid           ID/EX holds a live instruction
//   data_1, data_2     operand A; operand B / store data
//   imm, alu_src       immediate; 1 selects imm as operand B
//   alu_ctrl           operation code
//   rd, mem_wen        destination register; store request
//   flush              kill the current instruction (branch redirect)
//   alu_result         registered result
//   store_data         registered copy of data_2
//   rd_out             registered destination register
//   mem_wen_out        registered store request
//   out_valid          registered valid flag
//   stall_out          combinational upstream hold
// ---------------------------------------------------------------------------
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] data_1,
    input  logic [31:0] data_2,
    input  logic [31:0] imm,
    input  logic        alu_src,
    input  logic [3:0]  alu_ctrl,
    input  logic [4:0]  rd,
    input  logic        mem_wen,
    input  logic        flush,
    output logic [31:0] alu_result,
    output logic [31:0] store_data,
    output logic [4:0]  rd_out,
    output logic        mem_wen_out,
    output logic        out_valid,
    output logic        stall_out
);

    logic [31:0] op_b;
    logic [31:0] alu_out;

    assign op_b = alu_src ? imm : data_2;

    // Single-cycle ALU.  MUL and the unused codes 11-15 fall into the default
    // branch and give 0.  When the multiplier is enabled, MUL never takes this
    // path.
    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            4'd0:    alu_out = data_1 + op_b;
            4'd1:    alu_out = data_1 - op_b;
            4'd2:    alu_out = data_1 & op_b;
            4'd3:    alu_out = data_1 | op_b;
            4'd4:    alu_out = data_1 ^ op_b;
            4'd5:    alu_out = data_1 << op_b[4:0];
            4'd6:    alu_out = data_1 >> op_b[4:0];
            4'd7:    alu_out = $unsigned($signed(data_1) >>> op_b[4:0]);
            4'd8:    alu_out = {31'b0, $signed(data_1) < $signed(op_b)};
            4'd9:    alu_out = {31'b0, data_1 < op_b};
            default: alu_out = '0;
        endcase
    end

`ifdef EX_STAGE_MUL_EN

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MUL_RUN = 1'b1
    } state_t;

    state_t      state;
    logic [4:0]  mul_cnt;
    logic [31:0] mul_acc;     // running partial product
    logic [31:0] mul_mcand;   // multiplicand, shifted left once per iteration
    logic [31:0] mul_mplier;  // multiplier, shifted right once per iteration
    logic [31:0] mul_store;   // store data latched at MUL acceptance
    logic [4:0]  mul_rd;
    logic        mul_wen;
    logic        is_mul;
    logic [31:0] mul_partial;
    logic [31:0] mul_sum;

    assign is_mul      = (alu_ctrl == 4'd10);
    assign mul_partial = mul_mplier[0] ? mul_mcand : '0;
    assign mul_sum     = mul_acc + mul_partial;

    // Stall drops on the final iteration so that upstream advances on the
    // same edge that writes the product.
    always_comb begin
        stall_out = 1'b0;
        if (!reset && !flush) begin
            case (state)
                S_IDLE:    stall_out = in_valid && is_mul;
                S_MUL_RUN: stall_out = (mul_cnt != 5'd31);
                default:   stall_out = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            mul_cnt     <= '0;
            mul_acc     <= '0;
            mul_mcand   <= '0;
            mul_mplier  <= '0;
            mul_store   <= '0;
            mul_rd      <= '0;
            mul_wen     <= 1'b0;
            alu_result  <= '0;
            store_data  <= '0;
            rd_out      <= '0;
            mem_wen_out <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            // A bubble unless a branch below writes a real result.
            alu_result  <= '0;
            store_data  <= '0;
            rd_out      <= '0;
            mem_wen_out <= 1'b0;
            out_valid   <= 1'b0;
            if (flush) begin
                state   <= S_IDLE;
                mul_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (in_valid) begin
                            if (is_mul) begin
                                mul_mcand  <= data_1;
                                mul_mplier <= op_b;
                                mul_acc    <= '0;
                                mul_store  <= data_2;
                                mul_rd     <= rd;
                                mul_wen    <= mem_wen;
                                mul_cnt    <= '0;
                                state      <= S_MUL_RUN;
                            end else begin
                                alu_result  <= alu_out;
                                store_data  <= data_2;
                                rd_out      <= rd;
                                mem_wen_out <= mem_wen;
                                out_valid   <= 1'b1;
                            end
                        end
                    end
                    S_MUL_RUN: begin
                        mul_acc    <= mul_sum;
                        mul_mcand  <= mul_mcand << 1;
                        mul_mplier <= mul_mplier >> 1;
                        mul_cnt    <= mul_cnt + 5'd1;
                        if (mul_cnt == 5'd31) begin
                            alu_result  <= mul_sum;
                            store_data  <= mul_store;
                            rd_out      <= mul_rd;
                            mem_wen_out <= mul_wen;
                            out_valid   <= 1'b1;
                            mul_cnt     <= '0;
                            state       <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`else

    assign stall_out = 1'b0;

    always_ff @(posedge clk) begin
        if (reset || flush || !in_valid) begin
            alu_result  <= '0;
            store_data  <= '0;
            rd_out      <= '0;
            mem_wen_out <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            alu_result  <= alu_out;
            store_data  <= data_2;
            rd_out      <= rd;
            mem_wen_out <= mem_wen;
            out_valid   <= 1'b1;
        end
    end

`endif

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- directed bench for ex_stage.  Stimulus tasks push the expected
// {alu_result, store_data, rd_out, mem_wen_out} of each live instruction into
// exp_q.  A monitor pops the queue on every cycle that out_valid is high, so
// any missing, extra or wrong result is caught.  Bubbles, stall behaviour and
// reset/flush effects are checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] data_1;
    logic [31:0] data_2;
    logic [31:0] imm;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        mem_wen;
    logic        flush;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_out;
    logic        mem_wen_out;
    logic        out_valid;
    logic        stall_out;

    logic [69:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    ex_stage dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .data_1      (data_1),
        .data_2      (data_2),
        .imm         (imm),
        .alu_src     (alu_src),
        .alu_ctrl    (alu_ctrl),
        .rd          (rd),
        .mem_wen     (mem_wen),
        .flush       (flush),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .rd_out      (rd_out),
        .mem_wen_out (mem_wen_out),
        .out_valid   (out_valid),
        .stall_out   (stall_out)
    );

    // ---- clock ----
    always #5 clk = ~clk;

    // ---- check helper ----
    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---- monitor / scoreboard ----
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", {38'b0, alu_result}, 70'h0);
            end else begin
                check("result", {alu_result, store_data, rd_out, mem_wen_out}, exp_q.pop_front());
            end
        end
    end

    // ---- driver tasks ----
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic src, input logic [4:0] r,
                         input logic wen, input logic [31:0] exp_res);
        in_valid = 1'b1; alu_ctrl = op; data_1 = a; data_2 = b; imm = im;
        alu_src = src; rd = r; mem_wen = wen;
        exp_q.push_back({exp_res, b, r, wen});
        #1;
        check("stall_single_cycle", {69'b0, stall_out}, 70'h0);
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_bubble(input string name);
        check(name, {out_valid, alu_result, store_data, rd_out, mem_wen_out}, 71'h0);
    endtask

`ifdef EX_STAGE_MUL_EN
    // Presents a MUL and holds it while stall_out is high, as upstream would.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                           input logic [31:0] exp_res);
        int   stall_cycles;
        int   edges;
        logic s;
        stall_cycles = 0; edges = 0; s = 1'b1;
        in_valid = 1'b1; alu_ctrl = 4'd10; data_1 = a; data_2 = b; imm = 32'h0;
        alu_src = 1'b0; rd = r; mem_wen = 1'b0;
        exp_q.push_back({exp_res, b, r, 1'b0});
        while (s && edges < 40) begin
            #1;
            s = stall_out;
            if (s) stall_cycles++;
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        check("mul_stall_cycles", 70'(stall_cycles), 70'd32);
        check("mul_latency_edges", 70'(edges), 70'd33);
        check("mul_out_valid", {69'b0, out_valid}, 70'h1);
    endtask

    // Presents a MUL and lets it run for n edges without waiting for a result.
    task automatic start_mul(input int n);
        in_valid = 1'b1; alu_ctrl = 4'd10; data_1 = 32'h0000_0007; data_2 = 32'h0000_0009;
        imm = 32'h0; alu_src = 1'b0; rd = 5'd6; mem_wen = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask
`endif

    // ---- watchdog ----
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // ---- stimulus ----
    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; data_1 = 32'd1; data_2 = 32'd2;
        imm = 32'd0; alu_src = 1'b0; alu_ctrl = 4'd0; rd = 5'd9; mem_wen = 1'b1;

        // Reset has priority over a live instruction.
        repeat (3) @(posedge clk);
        #1;
        check_bubble("reset_outputs");
        check("reset_stall", {69'b0, stall_out}, 70'h0);
        reset = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_bubble("idle_bubble_after_reset");

        // Back-to-back single-cycle ops.
        issue(4'd0, 32'd5,         32'd7,         32'h0,  1'b0, 5'd3,  1'b0, 32'h0000_000C);
        issue(4'd1, 32'd10,        32'd3,         32'h0,  1'b0, 5'd4,  1'b0, 32'h0000_0007);
        issue(4'd1, 32'd0,         32'd1,         32'h0,  1'b0, 5'd5,  1'b0, 32'hFFFF_FFFF);
        issue(4'd0, 32'hFFFF_FFFF, 32'd1,         32'h0,  1'b0, 5'd6,  1'b0, 32'h0000_0000);
        issue(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0,  1'b0, 5'd7,  1'b0, 32'h00F0_00F0);
        issue(4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0,  1'b0, 5'd8,  1'b0, 32'hFFF0_FFF0);
        issue(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0,  1'b0, 5'd9,  1'b0, 32'hFF00_FF00);
        issue(4'd5, 32'd1,         32'h0000_0021, 32'h0,  1'b0, 5'd10, 1'b0, 32'h0000_0002);
        issue(4'd5, 32'd1,         32'h5555_AAAA, 32'd31, 1'b1, 5'd11, 1'b1, 32'h8000_0000);
        issue(4'd6, 32'h8000_0000, 32'h0,         32'd31, 1'b1, 5'd12, 1'b0, 32'h0000_0001);
        issue(4'd7, 32'h8000_0000, 32'h1234_5678, 32'd4,  1'b1, 5'd13, 1'b1, 32'hF800_0000);
        issue(4'd9, 32'd1,         32'hFFFF_FFFF, 32'h0,  1'b0, 5'd14, 1'b0, 32'h0000_0001);
        issue(4'd8, 32'd1,         32'hFFFF_FFFF, 32'h0,  1'b0, 5'd15, 1'b0, 32'h0000_0000);
        issue(4'd8, 32'hFFFF_FFFF, 32'd1,         32'h0,  1'b0, 5'd16, 1'b0, 32'h0000_0001);
        issue(4'd11, 32'd5,        32'd7,         32'h0,  1'b0, 5'd17, 1'b0, 32'h0000_0000);
        issue(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd31, 1'b1, 32'h0000_0000);
        idle_cycles(1);
        check_bubble("bubble_after_stream");

        // Flush kills a live instruction.
        in_valid = 1'b1; alu_ctrl = 4'd0; data_1 = 32'd3; data_2 = 32'd4; alu_src = 1'b0;
        rd = 5'd2; mem_wen = 1'b1; flush = 1'b1;
        #1;
        check("flush_stall", {69'b0, stall_out}, 70'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        check_bubble("flush_bubble");

`ifdef EX_STAGE_MUL_EN
        // Multi-cycle multiply with a held instruction.
        run_mul(32'h0001_0003, 32'h0000_0005, 5'd21, 32'h0005_000F);
        @(posedge clk); #1;
        check_bubble("bubble_after_mul");
        // A following single-cycle op proceeds normally.
        issue(4'd0, 32'd2, 32'd2, 32'h0, 1'b0, 5'd1, 1'b0, 32'h0000_0004);

        // Flush part-way through the multiply: no product may ever appear.
        start_mul(10);
        flush = 1'b1;
        #1;
        check("flush_mid_mul_stall", {69'b0, stall_out}, 70'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        check_bubble("flush_mid_mul_bubble");
        issue(4'd0, 32'd2, 32'd3, 32'h0, 1'b0, 5'd7, 1'b0, 32'h0000_0005);
        idle_cycles(40);

        // Reset part-way through the multiply.
        start_mul(5);
        reset = 1'b1;
        #1;
        check("reset_mid_mul_stall", {69'b0, stall_out}, 70'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        check_bubble("reset_mid_mul_outputs");
        issue(4'd0, 32'd1, 32'd1, 32'h0, 1'b0, 5'd3, 1'b0, 32'h0000_0002);
        idle_cycles(40);
`else
        // Without the multiplier, MUL is single-cycle and yields 0.
        issue(4'd10, 32'd3, 32'd4, 32'h0, 1'b0, 5'd20, 1'b0, 32'h0000_0000);
        issue(4'd0,  32'd6, 32'd1, 32'h0, 1'b0, 5'd21, 1'b0, 32'h0000_0007);

        // Reset with a live instruction following a real result.
        issue(4'd0, 32'd8, 32'd8, 32'h0, 1'b0, 5'd22, 1'b1, 32'h0000_0010);
        reset = 1'b1;
        in_valid = 1'b1;
        #1;
        check("reset_mid_stall", {69'b0, stall_out}, 70'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        check_bubble("reset_mid_outputs");
        issue(4'd0, 32'd1, 32'd1, 32'h0, 1'b0, 5'd3, 1'b0, 32'h0000_0002);
        idle_cycles(3);
`endif

        idle_cycles(2);
        check("queue_drained", 70'(exp_q.size()), 70'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
